// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter merging ALU and load writebacks onto one register-file write port.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);
    logic              r_last_b;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_block;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_xfer;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    always_comb begin
        w_block = rst_i | flush_i;
        w_a_gnt = !w_block && a_valid_i && (!b_valid_i || r_last_b);
        w_b_gnt = !w_block && b_valid_i && (!a_valid_i || !r_last_b);
        w_xfer  = w_a_gnt | w_b_gnt;
        w_addr  = w_a_gnt ? a_addr_i : b_addr_i;
        w_data  = w_a_gnt ? a_data_i : b_data_i;
        w_wr    = w_xfer && (w_addr != '0);
    end
    assign a_ready_o      = w_a_gnt;
    assign b_ready_o      = w_b_gnt;
    assign we_o           = r_we;
    assign waddr_o        = r_waddr;
    assign wdata_o        = r_wdata;
    assign conflict_cnt_o = r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_b <= 1'b1;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer) r_last_b <= w_b_gnt;
            r_we <= w_wr;
            // x0 writes complete the handshake but leave the write port untouched
            if (w_wr) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            if (a_valid_i && b_valid_i && !flush_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table, randomized model comparison and counter saturation checks.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_i, flush_i, a_valid_i, b_valid_i;
    logic [4:0]  a_addr_i, b_addr_i;
    logic [31:0] a_data_i, b_data_i;
    logic        a_ready_o, b_ready_o, we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [15:0] conflict_cnt_o;

    logic        s_rst, s_flush, s_av, s_bv;
    logic [4:0]  s_aa, s_ba;
    logic [31:0] s_ad, s_bd;
    logic        s_ar, s_br, s_we;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter u_dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .conflict_cnt_o(conflict_cnt_o)
    );

    rf_wb_arbiter #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(s_rst), .flush_i(s_flush),
        .a_valid_i(s_av), .a_addr_i(s_aa), .a_data_i(s_ad), .a_ready_o(s_ar),
        .b_valid_i(s_bv), .b_addr_i(s_ba), .b_data_i(s_bd), .b_ready_o(s_br),
        .we_o(s_we), .waddr_o(s_wa), .wdata_o(s_wd), .conflict_cnt_o(s_cnt)
    );

    typedef struct {
        logic        rst, flush, av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ear, ebr, ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        rst_i = r; flush_i = f;
        a_valid_i = av; a_addr_i = aa; a_data_i = ad;
        b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
    endtask

    logic        m_last_b, m_we, m_ga, m_gb;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_cnt;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        s_rst = 1; s_flush = 0; s_av = 0; s_bv = 0;
        s_aa = 5'd1; s_ba = 5'd2; s_ad = 32'h1; s_bd = 32'h2;
        //            rst flush av aa     ad             bv ba     bd           ar ebr we wa     wd             cnt
        vecs[0]  = '{1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0,        16'd0};
        vecs[1]  = '{0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 0, 1, 5'd5, 32'hDEADBEEF, 16'd0};
        vecs[2]  = '{1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0,        16'd0};
        vecs[3]  = '{0, 0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 0, 1, 5'd1, 32'hA1,       16'd1};
        vecs[4]  = '{0, 0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   0, 1, 1, 5'd2, 32'hB2,       16'd2};
        vecs[5]  = '{0, 0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   1, 0, 1, 5'd1, 32'hA1,       16'd3};
        vecs[6]  = '{0, 0, 1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2,   0, 1, 1, 5'd2, 32'hB2,       16'd4};
        vecs[7]  = '{0, 0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 1, 0, 5'd2, 32'hB2,       16'd4};
        vecs[8]  = '{1, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0,        16'd0};
        vecs[9]  = '{0, 0, 1, 5'd7, 32'h11,       1, 5'd7, 32'h22,   1, 0, 1, 5'd7, 32'h11,       16'd1};
        vecs[10] = '{0, 0, 0, 5'd0, 32'h0,        1, 5'd7, 32'h22,   0, 1, 1, 5'd7, 32'h22,       16'd1};
        vecs[11] = '{0, 1, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,   0, 0, 0, 5'd7, 32'h22,       16'd1};
        vecs[12] = '{0, 1, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,   0, 0, 0, 5'd7, 32'h22,       16'd1};
        vecs[13] = '{0, 0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,   1, 0, 1, 5'd3, 32'h33,       16'd2};
        vecs[14] = '{0, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd3, 32'h33,       16'd2};
        vecs[15] = '{1, 0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,   0, 0, 0, 5'd0, 32'h0,        16'd0};
        vecs[16] = '{1, 1, 1, 5'd9, 32'h99,       0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0,        16'd0};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            #1;
            chk($sformatf("vec%0d a_ready", i), {31'b0, a_ready_o}, {31'b0, vecs[i].ear});
            chk($sformatf("vec%0d b_ready", i), {31'b0, b_ready_o}, {31'b0, vecs[i].ebr});
            @(posedge clk); #1;
            chk($sformatf("vec%0d we", i), {31'b0, we_o}, {31'b0, vecs[i].ewe});
            chk($sformatf("vec%0d waddr", i), {27'b0, waddr_o}, {27'b0, vecs[i].ewa});
            chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].ewd);
            chk($sformatf("vec%0d cnt", i), {16'b0, conflict_cnt_o}, {16'b0, vecs[i].ecnt});
        end

        // The table ends in reset, so the model starts from the reset state
        m_last_b = 1; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
            m_ga = 0; m_gb = 0;
            if (!rst_i && !flush_i) begin
                if (a_valid_i && b_valid_i) begin
                    if (m_last_b) m_ga = 1; else m_gb = 1;
                end else begin
                    m_ga = a_valid_i;
                    m_gb = b_valid_i;
                end
            end
            #1;
            chk("rand a_ready", {31'b0, a_ready_o}, {31'b0, m_ga});
            chk("rand b_ready", {31'b0, b_ready_o}, {31'b0, m_gb});
            @(posedge clk);
            if (rst_i) begin
                m_last_b = 1; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
            end else begin
                if (m_ga || m_gb) m_last_b = m_gb;
                m_we = 0;
                if (m_ga && a_addr_i != 0) begin m_we = 1; m_wa = a_addr_i; m_wd = a_data_i; end
                if (m_gb && b_addr_i != 0) begin m_we = 1; m_wa = b_addr_i; m_wd = b_data_i; end
                if (a_valid_i && b_valid_i && !flush_i && m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            #1;
            chk("rand we", {31'b0, we_o}, {31'b0, m_we});
            chk("rand waddr", {27'b0, waddr_o}, {27'b0, m_wa});
            chk("rand wdata", wdata_o, m_wd);
            chk("rand cnt", {16'b0, conflict_cnt_o}, 32'(m_cnt));
        end

        @(negedge clk);
        s_rst = 0; s_av = 1; s_bv = 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 15 || i == 16 || i == 20) chk($sformatf("sat cnt after %0d", i), {28'b0, s_cnt}, 32'hF);
        end
        chk("sat we before rst", {31'b0, s_we}, 32'h1);
        @(negedge clk);
        s_rst = 1;
        #1;
        chk("sat ready in rst", {30'b0, s_ar, s_br}, 32'h0);
        @(posedge clk); #1;
        chk("sat cnt after rst", {28'b0, s_cnt}, 32'h0);
        chk("sat we after rst", {31'b0, s_we}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
